// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: inst_sram request/response channel, redirect inputs and the ID handoff.
// master = fetch queue side, slave = memory / pipeline side.
interface if_fetch_queue_if;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ID_allowin;
  logic        ID_flush;
  logic [31:0] ID_flush_target;
  logic        flush;
  logic [31:0] flush_target;
  logic        IF_to_ID;
  logic [65:0] IF_to_ID_bus;

  modport master (
    output inst_sram_en, inst_sram_addr, IF_to_ID, IF_to_ID_bus,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
           ID_allowin, ID_flush, ID_flush_target, flush, flush_target
  );

  modport slave (
    input  inst_sram_en, inst_sram_addr, IF_to_ID, IF_to_ID_bus,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
           ID_allowin, ID_flush, ID_flush_target, flush, flush_target
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch with up to MAX_OUTSTANDING requests in flight and a QDEPTH-entry queue to ID.
// Static B/BL prediction is built only when IF_BPRED_EN is defined.
module if_fetch_queue #(
  parameter int          QDEPTH          = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] PC_INIT         = 32'h1c000000
) (
  input logic            clk,
  input logic            rst,
  if_fetch_queue_if.master fq
);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = $clog2(QDEPTH) + 1;
  localparam int PW  = $clog2(QDEPTH);
  localparam int OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]    pc;
  logic           halt;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  discard;
  logic [CW-1:0]  occupancy;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [65:0]    q_mem [QDEPTH];
  logic [31:0]    opc_mem [MAX_OUTSTANDING];
  logic [OPW-1:0] opc_wr;
  logic [OPW-1:0] opc_rd;

  logic           redirect;
  logic           accept;
  logic           resp;
  logic           resp_keep;
  logic           adef_push;
  logic           push;
  logic           pop;
  logic [CW:0]    in_use;
  logic [OW-1:0]  outstanding_next;
  logic [31:0]    resp_pc;
  logic [65:0]    push_entry;
  logic [31:0]    pc_next;
  logic           pred_taken;
  logic [31:0]    pred_target;

  function automatic logic [OPW-1:0] opc_inc(input logic [OPW-1:0] p);
    return (p == OPW'(MAX_OUTSTANDING - 1)) ? '0 : p + OPW'(1);
  endfunction

  assign redirect = fq.flush | fq.ID_flush;
  assign in_use   = (CW+1)'(outstanding) + (CW+1)'(occupancy);

  // Credit check uses registered state only; a redirect cycle never blocks the request.
  assign fq.inst_sram_en   = ~halt & (pc[1:0] == 2'b00)
                           & (outstanding < OW'(MAX_OUTSTANDING))
                           & (in_use < (CW+1)'(QDEPTH));
  assign fq.inst_sram_addr = pc;

  assign accept    = fq.inst_sram_en & fq.inst_sram_addr_ok;
  assign resp      = fq.inst_sram_data_ok & (outstanding != '0);
  assign resp_keep = resp & (discard == '0) & ~redirect;
  assign resp_pc   = opc_mem[opc_rd];
  assign adef_push = ~halt & (pc[1:0] != 2'b00) & (outstanding == '0) & (discard == '0)
                   & (occupancy < CW'(QDEPTH)) & ~redirect;
  assign push      = resp_keep | adef_push;
  assign pop       = (occupancy != '0) & fq.ID_allowin & ~redirect;

  assign fq.IF_to_ID     = pop;
  assign fq.IF_to_ID_bus = (occupancy != '0) ? q_mem[head] : 66'd0;

  assign outstanding_next = outstanding + OW'(accept) - OW'(resp);

`ifdef IF_BPRED_EN
  logic        is_branch;
  logic [31:0] br_offs;

  assign is_branch   = (fq.inst_sram_rdata[31:26] == 6'h14) | (fq.inst_sram_rdata[31:26] == 6'h15);
  assign br_offs     = {{4{fq.inst_sram_rdata[9]}}, fq.inst_sram_rdata[9:0],
                        fq.inst_sram_rdata[25:10], 2'b00};
  assign pred_taken  = resp_keep & is_branch;
  assign pred_target = resp_pc + br_offs;
`else
  assign pred_taken  = 1'b0;
  assign pred_target = 32'h0;
`endif

  assign push_entry = adef_push ? {1'b0, 32'h0, pc, 1'b1}
                                : {pred_taken, fq.inst_sram_rdata, resp_pc, 1'b0};

  always_comb begin
    pc_next = pc;
    if (fq.flush)         pc_next = fq.flush_target;
    else if (fq.ID_flush) pc_next = fq.ID_flush_target;
    else if (pred_taken)  pc_next = pred_target;
    else if (accept)      pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= PC_INIT;
      halt        <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      occupancy   <= '0;
      head        <= '0;
      tail        <= '0;
      opc_wr      <= '0;
      opc_rd      <= '0;
    end else begin
      pc          <= pc_next;
      outstanding <= outstanding_next;
      // Every request still in flight after a redirect edge answers a stale PC.
      if (redirect || pred_taken)         discard <= outstanding_next;
      else if (resp && (discard != '0))   discard <= discard - OW'(1);
      if (redirect)                       halt <= 1'b0;
      else if (adef_push)                 halt <= 1'b1;
      if (redirect) begin
        occupancy <= '0;
        head      <= '0;
        tail      <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
      if (accept) opc_wr <= opc_inc(opc_wr);
      if (resp)   opc_rd <= opc_inc(opc_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (push)   q_mem[tail]     <= push_entry;
    if (accept) opc_mem[opc_wr] <= pc;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios then random traffic against an epoch-tagged
// transaction model (in-order memory, expected ID queue, fetch PC, halt).
module tb_if_fetch_queue;
  localparam int          QDEPTH  = 4;
  localparam int          MAXO    = 2;
  localparam logic [31:0] PC_INIT = 32'h1c000000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_fetch_queue_if f();

  if_fetch_queue #(.QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAXO), .PC_INIT(PC_INIT)) dut (
    .clk(clk),
    .rst(rst),
    .fq (f)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pend_addr[$];
  int          pend_ep[$];
  int          epoch = 0;
  logic [65:0] mq[$];
  logic [31:0] m_pc = PC_INIT;
  bit          m_halt = 1'b0;
  logic        obs_en;
  logic        obs_to_id;
  logic [31:0] obs_addr;
  logic [65:0] obs_bus;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef IF_BPRED_EN
    if (a == 32'h1c000200) return 32'h50001000;
`endif
    return {6'h00, a[27:2]};
  endfunction

  // One cycle: drive at posedge+1, sample/check at posedge+4, then advance the model.
  task automatic step(input bit allow, input bit aok, input bit dok,
                      input bit fl, input logic [31:0] ft,
                      input bit idf, input logic [31:0] idt);
    bit          redir, resp, keep, accept, exp_en, exp_to_id, adef_now, stale, is_b;
    logic [31:0] raddr, rinst;
    logic [65:0] e;
    int          inflight;
    redir    = fl | idf;
    inflight = pend_addr.size();
    f.ID_allowin        = allow;
    f.inst_sram_addr_ok = aok;
    f.inst_sram_data_ok = dok && (inflight > 0);
    f.inst_sram_rdata   = (inflight > 0) ? mem_word(pend_addr[0]) : 32'h0;
    f.flush             = fl;
    f.flush_target      = ft;
    f.ID_flush          = idf;
    f.ID_flush_target   = idt;
    #3;
    obs_en    = f.inst_sram_en;
    obs_to_id = f.IF_to_ID;
    obs_addr  = f.inst_sram_addr;
    obs_bus   = f.IF_to_ID_bus;
    exp_en    = !m_halt && (m_pc[1:0] == 2'b00) && (inflight < MAXO) && (inflight + mq.size() < QDEPTH);
    exp_to_id = (mq.size() > 0) && allow && !redir;
    chk("en", obs_en, exp_en);
    chk("to_id", obs_to_id, exp_to_id);
    if (exp_en) chk("addr", obs_addr, m_pc);
    if (mq.size() > 0) chk("head", obs_bus, mq[0]);

    resp     = dok && (inflight > 0);
    accept   = exp_en && aok;
    adef_now = !m_halt && (m_pc[1:0] != 2'b00) && (inflight == 0) && (mq.size() < QDEPTH) && !redir;
    is_b     = 1'b0;
    raddr    = 32'h0;
    rinst    = 32'h0;
    if (exp_to_id) e = mq.pop_front();
    if (resp) begin
      raddr = pend_addr.pop_front();
      stale = (pend_ep.pop_front() != epoch);
      keep  = !stale && !redir;
      rinst = mem_word(raddr);
`ifdef IF_BPRED_EN
      is_b  = keep && ((rinst[31:26] == 6'h14) || (rinst[31:26] == 6'h15));
`endif
      if (keep) mq.push_back({is_b, rinst, raddr, 1'b0});
    end
    if (adef_now) begin
      mq.push_back({1'b0, 32'h0, m_pc, 1'b1});
      m_halt = 1'b1;
    end
    if (accept) begin
      pend_addr.push_back(m_pc);
      pend_ep.push_back(epoch);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      mq.delete();
      m_halt = 1'b0;
      m_pc   = fl ? ft : idt;
      epoch++;
    end else if (is_b) begin
      m_pc = raddr + {{4{rinst[9]}}, rinst[9:0], rinst[25:10], 2'b00};
      epoch++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    f.ID_allowin = 1'b1;
    f.inst_sram_addr_ok = 1'b0;
    f.inst_sram_data_ok = 1'b0;
    f.flush = 1'b0;
    f.ID_flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3;
    chk("rst_to_id", f.IF_to_ID, 1'b0);
    chk("rst_bus", f.IF_to_ID_bus, 66'd0);
    chk("rst_en", f.inst_sram_en, 1'b1);
    chk("rst_addr", f.inst_sram_addr, PC_INIT);
    @(posedge clk); #1;
    pend_addr.delete();
    pend_ep.delete();
    mq.delete();
    m_pc   = PC_INIT;
    m_halt = 1'b0;
    epoch++;
    rst = 1'b0;
  endtask

  initial begin
    int          n;
    bit          got;
    logic [31:0] fpc;
    logic [31:0] tgt;
    int          r;
    f.ID_allowin = 1'b0;
    f.inst_sram_addr_ok = 1'b0;
    f.inst_sram_data_ok = 1'b0;
    f.inst_sram_rdata = 32'h0;
    f.flush = 1'b0;
    f.flush_target = 32'h0;
    f.ID_flush = 1'b0;
    f.ID_flush_target = 32'h0;
    do_reset();

    // single-cycle memory streaming
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      if (k == 0) chk("p1_en0", obs_en, 1'b1);
      if (k >= 2) begin
        chk("p1_to_id", obs_to_id, 1'b1);
        chk("p1_pc", obs_bus[32:1], PC_INIT + 32'(4 * (k - 2)));
      end
    end

    // back-pressure fills the queue, then drains exactly QDEPTH entries
    for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 0, 0, 0);
    chk("p2_en_full", obs_en, 1'b0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      if (obs_to_id) n++;
    end
    chk("p2_drain", n, QDEPTH);

    // flush with stale requests in flight
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 32'h1c000100, 0, 0);
    got = 1'b0; fpc = 32'h0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      if (obs_to_id) begin got = 1'b1; fpc = obs_bus[32:1]; end
    end
    chk("p3_first_pc", fpc, 32'h1c000100);

    // ID_flush coinciding with data_ok while 3 entries are queued
    n = 0;
    while (mq.size() != 3 && n < 20) begin
      step(0, 1, 1, 0, 0, 0, 0);
      n++;
    end
    chk("p4_fill_in_time", n < 20, 1'b1);
    step(1, 0, 1, 0, 0, 1, 32'h1c000300);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("p4_empty", obs_to_id, 1'b0);
    got = 1'b0; fpc = 32'h0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      if (obs_to_id) begin got = 1'b1; fpc = obs_bus[32:1]; end
    end
    chk("p4_first_pc", fpc, 32'h1c000300);

    // misaligned redirect: one adef entry, then fetch halts
    step(1, 0, 0, 0, 0, 1, 32'h1c000002);
    got = 1'b0; fpc = 32'h0;
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      if (obs_to_id && obs_bus[0]) begin got = 1'b1; fpc = obs_bus[32:1]; end
    end
    chk("p5_adef_pc", fpc, 32'h1c000002);
    chk("p5_halt_en", obs_en, 1'b0);
    step(1, 0, 0, 1, PC_INIT, 0, 0);

`ifdef IF_BPRED_EN
    begin
      logic [65:0] p0, p1;
      p0 = '0; p1 = '0; n = 0;
      step(1, 1, 1, 1, 32'h1c000200, 0, 0);
      for (int k = 0; k < 16 && n < 2; k++) begin
        step(1, 1, 1, 0, 0, 0, 0);
        if (obs_to_id) begin
          if (n == 0) p0 = obs_bus; else p1 = obs_bus;
          n++;
        end
      end
      chk("p6_pred", p0[65], 1'b1);
      chk("p6_br_pc", p0[32:1], 32'h1c000200);
      chk("p6_next_pc", p1[32:1], 32'h1c000210);
    end
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      r   = int'($urandom_range(0, 99));
      tgt = 32'h1c000000 + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 65,
           r < 3, tgt, (r >= 3) && (r < 7), tgt ^ 32'h40);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
